// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register and next-PC selection for the pipelined MIPS core.
// Latency: a req/eret/redirect lands on pc one cycle later; a buffered redirect lands one cycle after en returns.
// Backpressure: en=0 stalls the PC, and redirects that arrive during a stall are held (newest wins) until en=1.
//
// Optional feature: define PC_FETCH_CNT_EN to build the fetch counter; otherwise fetch_cnt is tied to zero.
//
// Ports:
//   clk, reset            clock (rising edge) and synchronous active-high reset
//   req                   exception/interrupt entry -> HANDLER_VEC (highest priority after reset)
//   eret, epc             exception return -> epc
//   en                    fetch advance enable (0 = stall)
//   br_valid, br_target   single-cycle redirect pulse and its target
//   pc, pc_plus4          current fetch PC and pc+4 (modulo 2^ADDR_W)
//   pend_valid            a redirect is buffered, waiting for en
//   fetch_exc, exc_code   AdEL on the current pc (code 4), else 0
//   fetch_cnt             count of advancing fetch cycles (0 when the feature is disabled)
module pc_redirect_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] HANDLER_VEC = ADDR_W'(32'h0000_4180),
  parameter logic [ADDR_W-1:0] IM_BASE     = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] IM_LIMIT    = ADDR_W'(32'h0000_6FFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              en,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              pend_valid,
  output logic              fetch_exc,
  output logic [4:0]        exc_code,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  // State register: PC, redirect-buffer state and buffered target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VEC;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Next-PC selection and redirect-buffer transitions.
  // req/eret ignore en and drop any buffered redirect. While stalled, a
  // redirect pulse is captured rather than lost; a later one overwrites it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;

    if (req) begin
      pc_d    = HANDLER_VEC;
      state_d = ST_IDLE;
    end else if (eret) begin
      pc_d    = epc;
      state_d = ST_IDLE;
    end else if (en) begin
      if (br_valid) begin
        pc_d = br_target;
      end else if (state_q == ST_PEND) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = pc_plus4;
      end
      state_d = ST_IDLE;
    end else if (br_valid) begin
      pend_tgt_d = br_target;
      state_d    = ST_PEND;
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign pend_valid = (state_q == ST_PEND);

  // AdEL: misaligned or outside the instruction memory window. Purely a flag;
  // the pipeline decides whether to raise req.
  assign fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LIMIT);
  assign exc_code  = fetch_exc ? 5'd4 : 5'd0;

`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;

  // Counts cycles in which fetch actually advances (en without req/eret).
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
    end else if (en && !req && !eret) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`else
  assign fetch_cnt = 32'd0;
`endif

endmodule
